// File: rtl/sync_fifo_fwft_pkg.sv
// Shared constants for the first-word-fall-through FIFO family.
// Holds the pointer-width helper and the default geometries used by the
// fetch buffer and UART queue instantiations.
package sync_fifo_fwft_pkg;

  // Default geometry of the instruction fetch buffer.
  localparam int FETCH_Q_ADDR_WIDTH = 3;
  localparam int FETCH_Q_DEPTH      = 1 << FETCH_Q_ADDR_WIDTH;

  // Default geometry of the debug/UART queues.
  localparam int UART_Q_ADDR_WIDTH  = 4;
  localparam int UART_Q_DEPTH       = 1 << UART_Q_ADDR_WIDTH;

  // Legal address width range for the FIFO core.
  localparam int FIFO_ADDR_WIDTH_MIN = 1;
  localparam int FIFO_ADDR_WIDTH_MAX = 12;

  // Read/write pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft_ram.sv
// DualPortRam storage for sync_fifo_fwft.
// One synchronous write port and one registered read port. A read of the
// address being written in the same cycle returns the old contents; the
// FIFO core hides that with its bypass path. Contents are never reset.
module sync_fifo_fwft_ram
  import sync_fifo_fwft_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
)
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [ADDR_WIDTH-1:0] rAddr,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Write port: store the incoming word when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wAddr] <= dataIn;
    end
  end

  // Read port: registered read, old data on a same-address collision.
  always_ff @(posedge clk) begin
    q <= mem[rAddr];
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through synchronous FIFO.
// valid/ready on both sides, storage in one DualPortRam. The head word is
// presented combinationally from the RAM's registered output, or from a
// one-entry bypass register when the head slot was written in the same
// cycle it was addressed for reading.
// Optional feature macro: FIFO_WATERMARK_EN adds peakCount and overflowSeen.
module sync_fifo_fwft
  import sync_fifo_fwft_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] inData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_WATERMARK_EN
  ,
  output logic [ADDR_WIDTH:0]   peakCount,
  output logic                  overflowSeen
`endif
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);

  logic [PTR_W-1:0]      wPtr;
  logic [PTR_W-1:0]      rPtr;
  logic [PTR_W-1:0]      rPtrNext;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;

  logic                  we;
  logic [ADDR_WIDTH-1:0] wAddr;
  logic [ADDR_WIDTH-1:0] rAddr;
  logic [DATA_WIDTH-1:0] dataIn;
  logic [DATA_WIDTH-1:0] q;

  logic                  bypassSel;
  logic [DATA_WIDTH-1:0] bypassData;

  // Occupancy flags from the wrap-bit pointer pair.
  assign empty = (wPtr == rPtr);
  assign full  = (wPtr[PTR_W-1] != rPtr[PTR_W-1]) &&
                 (wPtr[PTR_W-2:0] == rPtr[PTR_W-2:0]);
  assign count = wPtr - rPtr;

  // inReady depends only on state, so no path from outReady reaches it.
  assign inReady  = !full;
  assign outValid = !empty;

  assign push = inValid & inReady & rst_n;
  assign pop  = outValid & outReady & rst_n;

  // Write side of the RAM.
  assign we     = push;
  assign wAddr  = wPtr[ADDR_WIDTH-1:0];
  assign dataIn = inData;

  // Read address looks one entry ahead on a pop so q already holds the
  // new head in the following cycle.
  assign rPtrNext = rPtr + PTR_W'(pop);
  assign rAddr    = rPtrNext[ADDR_WIDTH-1:0];

  // Head word: bypass covers the write-into-the-slot-being-read case that
  // the RAM would answer with stale data.
  assign outData = bypassSel ? bypassData : q;

  sync_fifo_fwft_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dual_port_ram (
    .clk    (clk),
    .we     (we),
    .wAddr  (wAddr),
    .dataIn (dataIn),
    .rAddr  (rAddr),
    .q      (q)
  );

  // Pointer and bypass-select state; reset discards all entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wPtr      <= '0;
      rPtr      <= '0;
      bypassSel <= 1'b0;
    end else begin
      if (push) begin
        wPtr <= wPtr + PTR_W'(1);
      end
      rPtr      <= rPtrNext;
      bypassSel <= push & (wAddr == rAddr);
    end
  end

  // Bypass data capture; only meaningful when bypassSel is set.
  always_ff @(posedge clk) begin
    bypassData <= inData;
  end

`ifdef FIFO_WATERMARK_EN
  // High-water mark of the occupancy and sticky overflow-attempt flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peakCount    <= '0;
      overflowSeen <= 1'b0;
    end else begin
      if (count > peakCount) begin
        peakCount <= count;
      end
      if (inValid && full) begin
        overflowSeen <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench for sync_fifo_fwft: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_sync_fifo_fwft;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] inData;
  logic          outValid;
  logic          outReady;
  logic [DW-1:0] outData;
  logic [AW:0]   count;
`ifdef FIFO_WATERMARK_EN
  logic [AW:0]   peakCount;
  logic          overflowSeen;
  int            peak_ref;
  bit            ovf_ref;
`endif

  int            vectors = 0;
  int            errors  = 0;
  bit            chk_en  = 1'b0;
  logic [DW-1:0] ref_q[$];

  always #5 clk = ~clk;

  sync_fifo_fwft #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .inReady  (inReady),
    .inData   (inData),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outData),
    .count    (count)
`ifdef FIFO_WATERMARK_EN
    ,
    .peakCount    (peakCount),
    .overflowSeen (overflowSeen)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check outputs against the model state,
  // then advance the model with the FIFO rules for this edge.
  task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic rn);
    int sz;
    rst_n    = rn;
    inValid  = iv;
    inData   = id;
    outReady = ordy;
    @(negedge clk);
    sz = ref_q.size();
    if (chk_en) begin
      check("outValid", 64'(outValid), 64'(sz != 0));
      check("inReady",  64'(inReady),  64'(sz < DEPTH));
      check("count",    64'(count),    64'(sz));
      if (sz != 0) check("outData", 64'(outData), 64'(ref_q[0]));
`ifdef FIFO_WATERMARK_EN
      check("peakCount",    64'(peakCount),    64'(peak_ref));
      check("overflowSeen", 64'(overflowSeen), 64'(ovf_ref));
`endif
    end
    if (!rn) begin
      ref_q.delete();
`ifdef FIFO_WATERMARK_EN
      peak_ref = 0;
      ovf_ref  = 1'b0;
`endif
    end else begin
`ifdef FIFO_WATERMARK_EN
      if (sz > peak_ref) peak_ref = sz;
      if (iv && sz == DEPTH) ovf_ref = 1'b1;
`endif
      if (ordy && sz > 0) void'(ref_q.pop_front());
      if (iv && sz < DEPTH) ref_q.push_back(id);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    int pv;
    int pr;
    logic [DW-1:0] w;

    // Bring-up reset; state is unknown until the first reset edge.
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk_en = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    idle(1);

    // First word falls through one cycle after the push edge.
    cycle(1'b1, 32'hA5A5_0001, 1'b0, 1'b1);
    idle(1);
    drain();

    // Fill to full, attempt an extra word, then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b1);
    cycle(1'b1, 32'h0000_DEAD, 1'b0, 1'b1);
    cycle(1'b1, 32'h0000_DEAD, 1'b0, 1'b1);
    drain();

    // Full with simultaneous push and pop: only the pop takes effect.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(32'h100 + i), 1'b0, 1'b1);
    cycle(1'b1, 32'h0000_BEEF, 1'b1, 1'b1);
    idle(1);
    drain();

    // Streaming: one word per cycle each side, pointers wrap twice.
    for (int i = 0; i < 40; i++) cycle(1'b1, DW'(i), 1'b1, 1'b1);
    drain();

    // count=1 with same-cycle push and pop: new word becomes head via bypass.
    cycle(1'b1, 32'h0000_0077, 1'b0, 1'b1);
    cycle(1'b1, 32'h0000_1234, 1'b1, 1'b1);
    idle(1);
    drain();

    // Reset while full discards everything; FIFO works normally afterwards.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(32'h200 + i), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    idle(1);
    cycle(1'b1, 32'h0000_0055, 1'b0, 1'b1);
    idle(1);
    drain();

    // Watermark sequence: fill to 9, drain, then overflow attempt.
    cycle(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, DW'(32'h300 + i), 1'b0, 1'b1);
    drain();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(32'h400 + i), 1'b0, 1'b1);
    cycle(1'b1, 32'h0000_0BAD, 1'b0, 1'b1);
    idle(2);
    drain();

    // Randomized traffic with varying push/pop pressure and rare resets.
    for (int blk = 0; blk < 12; blk++) begin
      pv = $urandom_range(10, 95);
      pr = $urandom_range(10, 95);
      for (int i = 0; i < 250; i++) begin
        w = $urandom;
        cycle(($urandom_range(0, 99) < pv), w, ($urandom_range(0, 99) < pr),
              !($urandom_range(0, 299) == 0));
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
